hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage core. It sits beside the forwarding logic in ID/EX.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Squashes wrong-path instructions when a branch resolves taken in EX.
- Freezes the front end and EX while a multi-cycle mul/div occupies EX.
- Owns all PC/IF-ID/ID-EX write-enable and flush controls.

Parameters:
REG_ADDR_W, 5, register-address width.
MULDIV_LAT, 4, total EX-stage cycles for a mul/div. Legal range is 2..16; the block must fail elaboration outside this range.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  core clock, rising edge.
arst  in  1  asynchronous reset, active-high.
rs_id  in  REG_ADDR_W  source reg A of the instruction in ID.
rt_id  in  REG_ADDR_W  source reg B of the instruction in ID.
use_rs_id  in  1  ID instruction reads rs.
use_rt_id  in  1  ID instruction reads rt.
rd_id_ex  in  REG_ADDR_W  destination of the instruction in EX.
mem_read_id_ex  in  1  instruction in EX is a load.
reg_write_id_ex  in  1  instruction in EX writes the register file.
muldiv_id_ex  in  1  instruction in EX is a multi-cycle mul/div.
branch_taken_ex  in  1  branch in EX resolved taken.
pc_write  out  1  PC register enable.
if_id_write  out  1  IF/ID register enable.
if_id_flush  out  1  IF/ID load NOP.
id_ex_bubble  out  1  ID/EX load NOP (control bits cleared).
ex_hold  out  1  ID/EX and EX operand registers hold; EX/MEM loads bubble.
busy  out  1  mul/div sequence in progress.

Behaviour:
- Clocking and reset: one clock (clk); reset arst is asynchronous, active-high.
  - Reset forces state IDLE and cnt=0.
  - While arst is high, all inputs are ignored and outputs take idle values: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_hold=0, busy=0.
- Output timing: outputs are combinational from the registered state and current inputs. Stalls and flushes take effect in the same cycle the condition is seen.
- Register 0 never creates a hazard.
- load_use = mem_read_id_ex & reg_write_id_ex & (rd_id_ex≠0) & ((use_rs_id & rs_id==rd_id_ex) | (use_rt_id & rt_id==rd_id_ex)).
- FSM states: IDLE, MD_BUSY. The down-counter cnt is 4 bits wide.
- IDLE, priority order:
  1. muldiv_id_ex=1: ex_hold=1, pc_write=0, if_id_write=0, busy=1. Next state MD_BUSY with cnt=MULDIV_LAT-2. Any load_use is deferred; it is re-evaluated after release.
  2. branch_taken_ex=1: if_id_flush=1, id_ex_bubble=1, pc_write=1. Any load_use is suppressed because the ID instruction is wrong-path.
  3. load_use=1: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle. The next cycle the load is in MEM, so the hazard clears naturally.
  4. Otherwise: idle outputs.
- MD_BUSY:
  - cnt≠0: hold outputs as in IDLE case 1; cnt decrements.
  - cnt==0: final cycle. All holds are released, busy=0, and the result advances to MEM. Next state IDLE.
  - EX occupancy is exactly MULDIV_LAT cycles.
  - Back-to-back mul/div: the next one is detected in IDLE on the following cycle. No dead cycle is inserted.
- Simultaneous inputs: branch_taken_ex and muldiv_id_ex are mutually exclusive by ISA. The bench asserts this; if both are seen, muldiv wins.
- Reset mid-sequence: arst in MD_BUSY aborts immediately to IDLE.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles[CNT_W-1:0] and flush_count[CNT_W-1:0].
  - stall_cycles: +1 each cycle pc_write=0.
  - flush_count: +1 each cycle if_id_flush=1.
  - Both wrap modulo 2^CNT_W and clear on arst.
- Not defined: ports and logic are absent. Functional behaviour is identical either way.

Decomposition:
- Shared core package holds:
  - FSM state typedef (IDLE, MD_BUSY).
  - REG_ZERO constant.
  - MULDIV_LAT default.
- One natural sub-module: hazard_load_use_det, the purely combinational load_use compare. It is reusable by a future dual-issue ID.
- FSM and counter stay in the top module.

Test Plan:
- Load-use: lw $3 in EX (mem_read=1, rd=3), add $5,$3,$4 in ID (rs=3, use_rs=1) → 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; then idle outputs.
- Register 0: same as above but rd=0, rs=0 → no stall.
- Taken branch: branch_taken_ex=1 coincident with a load_use match → if_id_flush=1, id_ex_bubble=1, pc_write=1; no stall cycle.
- Mul/div with MULDIV_LAT=4: muldiv_id_ex=1 → ex_hold=1 and busy=1 for exactly 3 cycles, released on the 4th. A second muldiv immediately after gives 3 more hold cycles with no gap.
- Reset mid-sequence: arst pulsed during the 2nd hold cycle → outputs return to idle values immediately; state IDLE after release.
- HAZARD_PERF_CNT_EN: run the load-use scenario, the mul/div scenario at MULDIV_LAT=4, and one flush → stall_cycles=4, flush_count=1.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and constants for the hazard/stall sequencer
package hazard_stall_ctrl_pkg;

   // Sequencer states: normal issue, or a mul/div is occupying EX
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MD_BUSY = 1'b1
   } hz_state_e;

   // Architectural zero register; writes to it are discarded, so it never carries a hazard
   localparam int REG_ZERO = 0;

   // Default EX occupancy of a mul/div, in cycles
   localparam int MULDIV_LAT_DEF = 4;

   // Width of the mul/div down-counter (covers MULDIV_LAT up to 16)
   localparam int MD_CNT_W = 4;

   // Counter load value: the detect cycle in IDLE and the release cycle at cnt==0 are not counted
   function automatic logic [MD_CNT_W-1:0] md_cnt_init(input int lat);
      return MD_CNT_W'(lat - 2);
   endfunction

endpackage

// File: rtl/hazard_load_use_det.sv
// rtl/hazard_load_use_det.sv - combinational load-use compare between the ID sources and the EX load
module hazard_load_use_det
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_id,
   input  logic [REG_ADDR_W-1:0] rt_id,
   input  logic                  use_rs_id,
   input  logic                  use_rt_id,
   input  logic [REG_ADDR_W-1:0] rd_id_ex,
   input  logic                  mem_read_id_ex,
   input  logic                  reg_write_id_ex,
   output logic                  load_use
);

   logic ld_valid;
   logic rs_match;
   logic rt_match;

   // The load's data is not available until MEM, so forwarding cannot cover a consumer in ID
   assign ld_valid = mem_read_id_ex & reg_write_id_ex & (rd_id_ex != REG_ADDR_W'(REG_ZERO));
   assign rs_match = use_rs_id & (rs_id == rd_id_ex);
   assign rt_match = use_rt_id & (rt_id == rd_id_ex);
   assign load_use = ld_valid & (rs_match | rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard/stall sequencer; HAZARD_PERF_CNT_EN adds perf counters
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MULDIV_LAT = MULDIV_LAT_DEF
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W      = 32
`endif
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [REG_ADDR_W-1:0] rs_id,
   input  logic [REG_ADDR_W-1:0] rt_id,
   input  logic                  use_rs_id,
   input  logic                  use_rt_id,
   input  logic [REG_ADDR_W-1:0] rd_id_ex,
   input  logic                  mem_read_id_ex,
   input  logic                  reg_write_id_ex,
   input  logic                  muldiv_id_ex,
   input  logic                  branch_taken_ex,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  ex_hold,
   output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
`endif
);

   // Out-of-range latency cannot be represented by the down-counter
   if ((MULDIV_LAT < 2) || (MULDIV_LAT > 16)) begin : g_bad_lat
      $error("hazard_stall_ctrl: MULDIV_LAT must be in 2..16");
   end

   localparam logic [MD_CNT_W-1:0] CNT_INIT = md_cnt_init(MULDIV_LAT);

   hz_state_e             state_q, state_d;
   logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
   logic                  load_use;

   hazard_load_use_det #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_load_use_det (
      .rs_id          (rs_id),
      .rt_id          (rt_id),
      .use_rs_id      (use_rs_id),
      .use_rt_id      (use_rt_id),
      .rd_id_ex       (rd_id_ex),
      .mem_read_id_ex (mem_read_id_ex),
      .reg_write_id_ex(reg_write_id_ex),
      .load_use       (load_use)
   );

   // Next-state and same-cycle control outputs; reset forces idle controls regardless of inputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_hold      = 1'b0;
      busy         = 1'b0;
      if (!arst) begin
         case (state_q)
            ST_IDLE: begin
               if (muldiv_id_ex) begin
                  // A pending load-use in ID is simply re-evaluated once the freeze lifts
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  ex_hold     = 1'b1;
                  busy        = 1'b1;
                  state_d     = ST_MD_BUSY;
                  cnt_d       = CNT_INIT;
               end else if (branch_taken_ex) begin
                  // ID holds a wrong-path instruction, so its load-use match is irrelevant
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
               end else if (load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end
            end
            ST_MD_BUSY: begin
               if (cnt_q != '0) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  ex_hold     = 1'b1;
                  busy        = 1'b1;
                  cnt_d       = cnt_q - 1'b1;
               end else begin
                  // Release cycle: result moves on to MEM, next instruction enters EX
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Sequencer state and mul/div down-counter
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   // Counters wrap naturally at 2^CNT_W
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!pc_write) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
      if (if_id_flush) begin
         flush_count_d = flush_count_q + 1'b1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

   localparam int AW = 5;

   // Expected output patterns: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, busy}
   localparam logic [5:0] O_IDLE  = 6'b110000;
   localparam logic [5:0] O_LDUSE = 6'b000100;
   localparam logic [5:0] O_BRTK  = 6'b111100;
   localparam logic [5:0] O_HOLD  = 6'b000011;

   logic          clk = 1'b0;
   logic          arst;
   logic [AW-1:0] rs_id, rt_id, rd_id_ex;
   logic          use_rs_id, use_rt_id;
   logic          mem_read_id_ex, reg_write_id_ex, muldiv_id_ex, branch_taken_ex;
   logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]   stall_cycles, flush_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .REG_ADDR_W(AW),
      .MULDIV_LAT(4)
   ) dut (
      .clk            (clk),
      .arst           (arst),
      .rs_id          (rs_id),
      .rt_id          (rt_id),
      .use_rs_id      (use_rs_id),
      .use_rt_id      (use_rt_id),
      .rd_id_ex       (rd_id_ex),
      .mem_read_id_ex (mem_read_id_ex),
      .reg_write_id_ex(reg_write_id_ex),
      .muldiv_id_ex   (muldiv_id_ex),
      .branch_taken_ex(branch_taken_ex),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .id_ex_bubble   (id_ex_bubble),
      .ex_hold        (ex_hold),
      .busy           (busy)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
`endif
   );

   logic [5:0] obs;
   assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, busy};

   // Branch and mul/div can never be in EX together
   always @(negedge clk) begin
      if (!arst) begin
         assert (!(branch_taken_ex && muldiv_id_ex)) else $error("illegal stimulus: branch and muldiv together");
      end
   end

   task automatic chk(input string tag, input logic [5:0] exp);
      #1;
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      rs_id = '0; rt_id = '0; rd_id_ex = '0;
      use_rs_id = 1'b0; use_rt_id = 1'b0;
      mem_read_id_ex = 1'b0; reg_write_id_ex = 1'b0;
      muldiv_id_ex = 1'b0; branch_taken_ex = 1'b0;
   endtask

   task automatic set_lw(input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic urs,
                         input logic [AW-1:0] rt, input logic urt);
      clr();
      mem_read_id_ex = 1'b1; reg_write_id_ex = 1'b1; rd_id_ex = rd;
      rs_id = rs; use_rs_id = urs; rt_id = rt; use_rt_id = urt;
   endtask

   initial begin
      arst = 1'b1;
      clr();
      // Reset with hostile inputs: outputs must stay idle
      @(negedge clk);
      muldiv_id_ex = 1'b1;
      set_lw(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
      muldiv_id_ex = 1'b1;
      chk("reset_idle", O_IDLE);
      clr();
      arst = 1'b0;
      @(negedge clk); chk("post_reset_idle", O_IDLE);

      // Load-use via rs, one bubble then the load has moved to MEM
      @(negedge clk); set_lw(5'd3, 5'd3, 1'b1, 5'd4, 1'b1); chk("lduse_rs", O_LDUSE);
      @(negedge clk); clr(); rs_id = 5'd3; use_rs_id = 1'b1; reg_write_id_ex = 1'b1; rd_id_ex = 5'd5;
      chk("lduse_clear", O_IDLE);
      // Load-use via rt; rt not read; register 0; non-writing load
      @(negedge clk); set_lw(5'd7, 5'd1, 1'b1, 5'd7, 1'b1); chk("lduse_rt", O_LDUSE);
      @(negedge clk); set_lw(5'd7, 5'd1, 1'b1, 5'd7, 1'b0); chk("rt_unused", O_IDLE);
      @(negedge clk); set_lw(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); chk("reg_zero", O_IDLE);
      @(negedge clk); set_lw(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); reg_write_id_ex = 1'b0;
      chk("no_regwrite", O_IDLE);

      // Taken branch with a coincident load-use match: flush, no stall
      @(negedge clk); set_lw(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); branch_taken_ex = 1'b1;
      chk("branch_flush", O_BRTK);
      @(negedge clk); clr(); chk("branch_after", O_IDLE);

      // Mul/div latency 4: three hold cycles, released on the fourth, back-to-back with no gap
      @(negedge clk); muldiv_id_ex = 1'b1; chk("md1_hold1", O_HOLD);
      @(negedge clk); chk("md1_hold2", O_HOLD);
      @(negedge clk); chk("md1_hold3", O_HOLD);
      @(negedge clk); chk("md1_release", O_IDLE);
      @(negedge clk); chk("md2_hold1", O_HOLD);
      @(negedge clk); set_lw(5'd2, 5'd2, 1'b1, 5'd0, 1'b0); muldiv_id_ex = 1'b1;
      chk("md2_hold2_lduse_deferred", O_HOLD);
      @(negedge clk); clr(); muldiv_id_ex = 1'b1; chk("md2_hold3", O_HOLD);
      @(negedge clk); chk("md2_release", O_IDLE);
      @(negedge clk); clr(); chk("md_done_idle", O_IDLE);

      // Reset pulsed during the second hold cycle aborts the sequence
      @(negedge clk); muldiv_id_ex = 1'b1; chk("md3_hold1", O_HOLD);
      @(negedge clk); chk("md3_hold2", O_HOLD);
      arst = 1'b1;
      chk("rst_mid_idle", O_IDLE);
      clr();
      arst = 1'b0;
      @(negedge clk); chk("rst_mid_after1", O_IDLE);
      @(negedge clk); chk("rst_mid_after2", O_IDLE);

      // Counter scenario: one load-use stall, one mul/div (3 stalls), one flush
      @(negedge clk); set_lw(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); chk("perf_lduse", O_LDUSE);
      @(negedge clk); clr(); muldiv_id_ex = 1'b1; chk("perf_md_hold1", O_HOLD);
      @(negedge clk); chk("perf_md_hold2", O_HOLD);
      @(negedge clk); chk("perf_md_hold3", O_HOLD);
      @(negedge clk); chk("perf_md_release", O_IDLE);
      @(negedge clk); clr(); branch_taken_ex = 1'b1; chk("perf_flush", O_BRTK);
      @(negedge clk); clr(); chk("perf_end_idle", O_IDLE);
`ifdef HAZARD_PERF_CNT_EN
      chk32("stall_cycles", stall_cycles, 32'd4);
      chk32("flush_count", flush_count, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
